// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS pipeline stage registers.
//   - exception-code width and the codes the front end can raise
//   - default bubble encoding and reset PC
//   - bit positions of the register-specifier fields in an instruction word
package mips_pkg;

    localparam int MIPS_EXC_W = 5;

    localparam logic [MIPS_EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [MIPS_EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [MIPS_EXC_W-1:0] EXC_RI   = 5'd10;

    localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] MIPS_RESET_PC  = 32'h0000_3000;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one this edge (sticks at all-ones)
//   clr        : zero the counter this edge; wins over inc
//   cnt        : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: Fetch -> Decode pipeline register.
// Captures instruction, PC, exception code and delay-slot flag from F each
// edge, with per-edge priority flush > stall > load. Presents PC+4/PC+8 and
// pre-decoded rs/rt/rd fields, and counts held cycles and inserted bubbles.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   stall, flush, cnt_clr   : hazard hold, D-stage kill, counter clear
//   f_valid/f_instr/f_pc/f_exc/f_bd : fetch-side inputs
//   d_valid/d_instr/d_pc/d_exc/d_bd : registered D-stage outputs
//   d_pc4, d_pc8, d_rs, d_rt, d_rd  : derived from the registers only
//   d_stalled               : D was held on the last edge
//   stall_cnt, bubble_cnt   : saturating performance counters
// State is implicit in d_valid/d_stalled: empty, live, or held.
module fd_pipe_reg
    import mips_pkg::*;
#(
    parameter int               PC_W      = 32,
    parameter int               INSTR_W   = 32,
    parameter logic [PC_W-1:0]    RESET_PC  = MIPS_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = MIPS_NOP_INSTR,
    parameter int               EXC_W     = MIPS_EXC_W,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic               f_valid,
    input  logic [INSTR_W-1:0] f_instr,
    input  logic [PC_W-1:0]    f_pc,
    input  logic [EXC_W-1:0]   f_exc,
    input  logic               f_bd,
    output logic               d_valid,
    output logic [INSTR_W-1:0] d_instr,
    output logic [PC_W-1:0]    d_pc,
    output logic [PC_W-1:0]    d_pc4,
    output logic [PC_W-1:0]    d_pc8,
    output logic [EXC_W-1:0]   d_exc,
    output logic               d_bd,
    output logic [4:0]         d_rs,
    output logic [4:0]         d_rt,
    output logic [4:0]         d_rd,
    output logic               d_stalled,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic               d_valid_q,   d_valid_d;
    logic [INSTR_W-1:0] d_instr_q,   d_instr_d;
    logic [PC_W-1:0]    d_pc_q,      d_pc_d;
    logic [EXC_W-1:0]   d_exc_q,     d_exc_d;
    logic               d_bd_q,      d_bd_d;
    logic               d_stalled_q, d_stalled_d;

    logic stall_inc;
    logic bubble_inc;

    always_comb begin
        d_valid_d   = d_valid_q;
        d_instr_d   = d_instr_q;
        d_pc_d      = d_pc_q;
        d_exc_d     = d_exc_q;
        d_bd_d      = d_bd_q;
        d_stalled_d = 1'b0;
        stall_inc   = 1'b0;
        bubble_inc  = 1'b0;

        if (flush) begin
            d_valid_d  = 1'b0;
            d_instr_d  = NOP_INSTR;
            d_pc_d     = RESET_PC;
            d_exc_d    = '0;
            d_bd_d     = 1'b0;
            bubble_inc = 1'b1;
        end else if (stall) begin
            d_stalled_d = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            d_valid_d  = f_valid;
            d_pc_d     = f_pc;
            d_exc_d    = f_exc;
            d_bd_d     = f_bd;
            // A faulting or invalid fetch must not reach decode as a real
            // instruction, but PC and exception code still travel so EPC
            // is correct when the exception is taken.
            if (f_valid && (f_exc == EXC_W'(EXC_NONE))) begin
                d_instr_d = f_instr;
            end else begin
                d_instr_d = NOP_INSTR;
            end
            bubble_inc = ~f_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_valid_q   <= 1'b0;
            d_instr_q   <= NOP_INSTR;
            d_pc_q      <= RESET_PC;
            d_exc_q     <= '0;
            d_bd_q      <= 1'b0;
            d_stalled_q <= 1'b0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_instr_q   <= d_instr_d;
            d_pc_q      <= d_pc_d;
            d_exc_q     <= d_exc_d;
            d_bd_q      <= d_bd_d;
            d_stalled_q <= d_stalled_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (bubble_inc),
        .clr   (cnt_clr),
        .cnt   (bubble_cnt)
    );

    assign d_valid   = d_valid_q;
    assign d_instr   = d_instr_q;
    assign d_pc      = d_pc_q;
    assign d_exc     = d_exc_q;
    assign d_bd      = d_bd_q;
    assign d_stalled = d_stalled_q;

    // PC arithmetic wraps modulo 2^PC_W.
    assign d_pc4 = d_pc_q + PC_W'(4);
    assign d_pc8 = d_pc_q + PC_W'(8);

    assign d_rs = d_instr_q[RS_HI:RS_LO];
    assign d_rt = d_instr_q[RT_HI:RT_LO];
    assign d_rd = d_instr_q[RD_HI:RD_LO];

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: inputs change on the falling edge,
// outputs are compared on the following falling edge.
module tb_fd_pipe_reg;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        cnt_clr;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [4:0]  f_exc;
    logic        f_bd;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc4;
    logic [31:0] d_pc8;
    logic [4:0]  d_exc;
    logic        d_bd;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_rd;
    logic        d_stalled;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    fd_pipe_reg dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .f_valid    (f_valid),
        .f_instr    (f_instr),
        .f_pc       (f_pc),
        .f_exc      (f_exc),
        .f_bd       (f_bd),
        .d_valid    (d_valid),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .d_pc4      (d_pc4),
        .d_pc8      (d_pc8),
        .d_exc      (d_exc),
        .d_bd       (d_bd),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rd       (d_rd),
        .d_stalled  (d_stalled),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        f_valid = 1'b0;
        f_instr = 32'h0;
        f_pc    = 32'h0;
        f_exc   = 5'd0;
        f_bd    = 1'b0;

        // Reset state
        @(negedge clk);
        step();
        chk("rst_valid",   32'(d_valid),    32'h0);
        chk("rst_instr",   d_instr,         32'h0);
        chk("rst_pc",      d_pc,            32'h3000);
        chk("rst_pc4",     d_pc4,           32'h3004);
        chk("rst_exc",     32'(d_exc),      32'h0);
        chk("rst_bd",      32'(d_bd),       32'h0);
        chk("rst_stalled", 32'(d_stalled),  32'h0);
        chk("rst_scnt",    32'(stall_cnt),  32'h0);
        chk("rst_bcnt",    32'(bubble_cnt), 32'h0);

        // First load: lui $1,0x1234
        reset_n = 1'b1;
        f_valid = 1'b1;
        f_instr = 32'h3C01_1234;
        f_pc    = 32'h3000;
        step();
        chk("ld_instr", d_instr,         32'h3C01_1234);
        chk("ld_pc4",   d_pc4,           32'h3004);
        chk("ld_pc8",   d_pc8,           32'h3008);
        chk("ld_rt",    32'(d_rt),       32'h1);
        chk("ld_rs",    32'(d_rs),       32'h0);
        chk("ld_valid", 32'(d_valid),    32'h1);
        chk("ld_bcnt",  32'(bubble_cnt), 32'h0);

        // Three-cycle stall while F moves on
        stall   = 1'b1;
        f_instr = 32'h2021_0001;
        f_pc    = 32'h3004;
        step();
        step();
        step();
        chk("st_instr",   d_instr,        32'h3C01_1234);
        chk("st_pc",      d_pc,           32'h3000);
        chk("st_stalled", 32'(d_stalled), 32'h1);
        chk("st_scnt",    32'(stall_cnt), 32'h3);

        stall = 1'b0;
        step();
        chk("rel_instr",   d_instr,        32'h2021_0001);
        chk("rel_pc",      d_pc,           32'h3004);
        chk("rel_stalled", 32'(d_stalled), 32'h0);
        chk("rel_rs",      32'(d_rs),      32'h1);
        chk("rel_rt",      32'(d_rt),      32'h1);
        chk("rel_rd",      32'(d_rd),      32'h0);
        chk("rel_scnt",    32'(stall_cnt), 32'h3);

        // Flush and stall together: flush wins
        flush = 1'b1;
        stall = 1'b1;
        step();
        chk("fl_valid",   32'(d_valid),    32'h0);
        chk("fl_instr",   d_instr,         32'h0);
        chk("fl_pc",      d_pc,            32'h3000);
        chk("fl_bcnt",    32'(bubble_cnt), 32'h1);
        chk("fl_scnt",    32'(stall_cnt),  32'h3);
        chk("fl_stalled", 32'(d_stalled),  32'h0);
        flush = 1'b0;
        stall = 1'b0;

        // AdEL on fetch: instruction squashed, PC/exc carried
        f_valid = 1'b1;
        f_exc   = 5'd4;
        f_pc    = 32'h3001;
        f_instr = 32'hFFFF_FFFF;
        f_bd    = 1'b1;
        step();
        chk("exc_instr", d_instr,         32'h0);
        chk("exc_code",  32'(d_exc),      32'h4);
        chk("exc_pc",    d_pc,            32'h3001);
        chk("exc_pc4",   d_pc4,           32'h3005);
        chk("exc_valid", 32'(d_valid),    32'h1);
        chk("exc_bd",    32'(d_bd),       32'h1);
        chk("exc_bcnt",  32'(bubble_cnt), 32'h1);

        // Invalid fetch counts as a bubble
        f_valid = 1'b0;
        f_exc   = 5'd0;
        f_bd    = 1'b0;
        f_pc    = 32'h3008;
        f_instr = 32'h1234_5678;
        step();
        chk("inv_valid", 32'(d_valid),    32'h0);
        chk("inv_instr", d_instr,         32'h0);
        chk("inv_pc",    d_pc,            32'h3008);
        chk("inv_bcnt",  32'(bubble_cnt), 32'h2);

        // PC wrap: add $3,$1,$2 at 0xFFFF_FFFC
        f_valid = 1'b1;
        f_pc    = 32'hFFFF_FFFC;
        f_instr = 32'h0022_1820;
        step();
        chk("wr_pc4", d_pc4,      32'h0);
        chk("wr_pc8", d_pc8,      32'h4);
        chk("wr_rs",  32'(d_rs),  32'h1);
        chk("wr_rt",  32'(d_rt),  32'h2);
        chk("wr_rd",  32'(d_rd),  32'h3);

        // cnt_clr beats a same-cycle bubble increment; data still loads
        cnt_clr = 1'b1;
        f_valid = 1'b0;
        f_pc    = 32'h4000;
        step();
        chk("clr_bcnt",  32'(bubble_cnt), 32'h0);
        chk("clr_scnt",  32'(stall_cnt),  32'h0);
        chk("clr_pc",    d_pc,            32'h4000);
        chk("clr_valid", 32'(d_valid),    32'h0);
        cnt_clr = 1'b0;

        // Saturate stall_cnt
        stall = 1'b1;
        f_pc  = 32'h5000;
        for (int i = 0; i < 65541; i++) step();
        chk("sat_scnt",    32'(stall_cnt), 32'hFFFF);
        chk("sat_stalled", 32'(d_stalled), 32'h1);
        chk("sat_pc",      d_pc,           32'h4000);

        cnt_clr = 1'b1;
        step();
        chk("satclr_scnt", 32'(stall_cnt), 32'h0);
        chk("satclr_pc",   d_pc,           32'h4000);
        cnt_clr = 1'b0;
        step();
        chk("post_scnt", 32'(stall_cnt), 32'h1);

        // Asynchronous reset mid-stall, between edges
        f_valid = 1'b1;
        f_pc    = 32'h6000;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid",   32'(d_valid),   32'h0);
        chk("ar_pc",      d_pc,           32'h3000);
        chk("ar_instr",   d_instr,        32'h0);
        chk("ar_stalled", 32'(d_stalled), 32'h0);
        chk("ar_scnt",    32'(stall_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        stall   = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
Parametrised Fetch→Decode pipeline register for the five-stage MIPS core.
- Captures the fetched instruction, PC and fetch-side exception status on each clock edge.
- Supports stall (hold), flush (bubble insertion) and exception squash.
- Presents pre-decoded register fields and PC+4/PC+8 to the D stage.
- Keeps saturating stall and bubble counters for performance debug.

Parameters:
- PC_W, 32, PC width in bits.
- INSTR_W, 32, instruction width in bits.
- RESET_PC, 32'h0000_3000, value loaded into d_pc at reset and on flush.
- NOP_INSTR, 32'h0000_0000, encoding inserted as a bubble.
- EXC_W, 5, exception-code width; 0 means no exception.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit hold request.
- flush  in  1  kill D-stage contents (e.g. exception return, mispredict).
- cnt_clr  in  1  synchronous clear of both counters.
- f_valid  in  1  F stage holds a real instruction.
- f_instr  in  INSTR_W  fetched instruction.
- f_pc  in  PC_W  PC of f_instr.
- f_exc  in  EXC_W  fetch exception code (e.g. AdEL).
- f_bd  in  1  f_instr sits in a branch delay slot.
- d_valid  out  1  D stage holds a live instruction.
- d_instr  out  INSTR_W  registered instruction.
- d_pc  out  PC_W  registered PC.
- d_pc4  out  PC_W  d_pc + 4.
- d_pc8  out  PC_W  d_pc + 8, the link address.
- d_exc  out  EXC_W  registered exception code.
- d_bd  out  1  registered delay-slot flag.
- d_rs  out  5  d_instr[25:21].
- d_rt  out  5  d_instr[20:16].
- d_rd  out  5  d_instr[15:11].
- d_stalled  out  1  high while the stage is held this cycle.
- stall_cnt  out  CNT_W  count of held cycles.
- bubble_cnt  out  CNT_W  count of inserted bubbles.

Behaviour:
- Reset, asynchronous on reset_n=0, sets:
  - d_valid=0, d_instr=NOP_INSTR, d_pc=RESET_PC, d_exc=0, d_bd=0;
  - d_stalled=0, stall_cnt=0, bubble_cnt=0.
  - Reset asserted mid-stall or mid-flush overrides everything immediately.
- Per-edge priority is flush > stall > load. This is the only state machine; state is implicit in d_valid/d_stalled.
- flush=1:
  - d_valid=0, d_instr=NOP_INSTR, d_exc=0, d_bd=0, d_pc=RESET_PC.
  - bubble_cnt increments and saturates at all-ones.
  - Flush together with stall: flush wins, stall_cnt does not increment, d_stalled=0.
- stall=1 (no flush):
  - All d_* data registers hold their values.
  - d_stalled=1 and stall_cnt increments (saturating).
  - Holding continues across any number of cycles; on the first edge with stall=0 the current F inputs are loaded.
- Load (no stall, no flush):
  - d_valid=f_valid, d_pc=f_pc, d_exc=f_exc, d_bd=f_bd, d_stalled=0.
  - d_instr=f_instr when f_exc==0 and f_valid=1.
  - d_instr=NOP_INSTR otherwise (exception squash or invalid fetch). d_exc and d_pc are still carried so EPC is correct.
  - f_valid=0 with no flush also counts as a bubble: bubble_cnt increments.
- cnt_clr=1 zeroes both counters on that edge. It takes precedence over increments in the same cycle and does not affect pipeline data.
- d_pc4, d_pc8, d_rs, d_rt and d_rd are combinational from the registers.
  - PC arithmetic is modulo 2^PC_W and wraps silently (0xFFFF_FFFC+4 → 0).
- Latency is one cycle from F inputs to D outputs. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package `mips_pkg`:
  - EXC_W and the exception-code constants (EXC_NONE=0, EXC_ADEL=4, EXC_RI=10);
  - NOP_INSTR and RESET_PC defaults;
  - register-field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO).
- One natural sub-module, `sat_counter` (parameter CNT_W; inputs inc and clr), instantiated twice for stall_cnt and bubble_cnt.
- The same register core is reused later for the D/E, E/M and M/W stages.

Test Plan:
- Reset release, then load f_instr=0x3C01_1234, f_pc=0x3000, f_valid=1 → next cycle d_instr=0x3C01_1234, d_pc4=0x3004, d_pc8=0x3008, d_rt=1, d_valid=1.
- stall=1 for 3 cycles while F changes to 0x2021_0001 → D outputs unchanged, d_stalled=1, stall_cnt=3; stall drops → D loads 0x2021_0001.
- flush=1 and stall=1 together → d_valid=0, d_instr=0, d_pc=0x3000, bubble_cnt+1, stall_cnt unchanged.
- f_exc=4 (AdEL), f_pc=0x3001, f_instr=0xFFFF_FFFF → d_instr=0, d_exc=4, d_pc=0x3001, d_valid=1.
- Drive stall for 2^CNT_W+5 cycles → stall_cnt saturates at 0xFFFF; then cnt_clr=1 with stall=1 → stall_cnt=0.
- reset_n pulsed low mid-stall, between clock edges → outputs return to reset values immediately, before the next clk edge.
